// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 definitions: the B-channel response encoding and its classification.
package axi4_globals_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } bresp_e;

    // SLVERR and DECERR both have the upper bit set; OKAY and EXOKAY do not.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi4_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module axi4_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next value: increment only while headroom remains.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi4_wr_resp_receiver.sv
// Master-side AXI4 B-channel receiver: tracks issued write IDs, matches
// incoming responses against them and emits one completion record per beat.
module axi4_wr_resp_receiver
    import axi4_globals_pkg::*;
#(
    parameter int AXI_IW    = 4,
    parameter int AXI_UW    = 4,
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                           axi_clk_i,
    input  logic                           axi_rstn_i,
    input  logic                           issue_valid_i,
    input  logic [AXI_IW-1:0]              issue_id_i,
    output logic                           issue_ready_o,
    input  logic [AXI_IW-1:0]              axi_bid_i,
    input  logic [1:0]                     axi_bresp_i,
    input  logic [AXI_UW-1:0]              axi_buser_i,
    input  logic                           axi_bvalid_i,
    output logic                           axi_bready_o,
    output logic                           cmpl_valid_o,
    input  logic                           cmpl_ready_i,
    output logic [AXI_IW-1:0]              cmpl_id_o,
    output logic [1:0]                     cmpl_resp_o,
    output logic [AXI_UW-1:0]              cmpl_user_o,
    output logic                           cmpl_unexp_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt_o,
    output logic [CNT_W-1:0]               okay_cnt_o,
    output logic [CNT_W-1:0]               err_cnt_o,
    output logic [CNT_W-1:0]               unexp_cnt_o
);

    localparam int NID = 1 << AXI_IW;
    localparam int OW  = $clog2(MAX_OUTST+1);

    logic [NID-1:0][OW-1:0] cnt_q, cnt_d;
    logic [OW-1:0]          total_q, total_d;

    logic              cv_q, cv_d;
    logic [AXI_IW-1:0] cid_q, cid_d;
    logic [1:0]        cresp_q, cresp_d;
    logic [AXI_UW-1:0] cuser_q, cuser_d;
    logic              cunexp_q, cunexp_d;

    logic issue_fire, b_fire, b_hit, b_dec;

    // Handshakes are qualified with pre-edge state, so an issue while full
    // stays ignored even if a B beat frees a slot in the same cycle.
    assign issue_ready_o = (total_q < OW'(MAX_OUTST));
    assign axi_bready_o  = !cv_q || cmpl_ready_i;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign b_fire        = axi_bvalid_i && axi_bready_o;
    assign b_hit         = (cnt_q[axi_bid_i] != '0);
    assign b_dec         = b_fire && b_hit;

    // Per-ID and total outstanding counts; same-ID issue+retire nets to zero.
    always_comb begin
        cnt_d   = cnt_q;
        total_d = total_q;
        for (int i = 0; i < NID; i++) begin
            if (issue_fire && (issue_id_i == AXI_IW'(i))) cnt_d[i] = cnt_d[i] + OW'(1);
            if (b_dec && (axi_bid_i == AXI_IW'(i)))       cnt_d[i] = cnt_d[i] - OW'(1);
        end
        if (issue_fire) total_d = total_d + OW'(1);
        if (b_dec)      total_d = total_d - OW'(1);
    end

    // Outstanding-count registers.
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            cnt_q   <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

    // Completion record: load on B beat, hold under backpressure, drop valid on accept.
    always_comb begin
        cv_d     = cv_q;
        cid_d    = cid_q;
        cresp_d  = cresp_q;
        cuser_d  = cuser_q;
        cunexp_d = cunexp_q;
        if (b_fire) begin
            cv_d     = 1'b1;
            cid_d    = axi_bid_i;
            cresp_d  = axi_bresp_i;
            cuser_d  = axi_buser_i;
            cunexp_d = !b_hit;
        end else if (cmpl_ready_i) begin
            cv_d     = 1'b0;
        end
    end

    // Completion record registers.
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            cv_q     <= 1'b0;
            cid_q    <= '0;
            cresp_q  <= '0;
            cuser_q  <= '0;
            cunexp_q <= 1'b0;
        end else begin
            cv_q     <= cv_d;
            cid_q    <= cid_d;
            cresp_q  <= cresp_d;
            cuser_q  <= cuser_d;
            cunexp_q <= cunexp_d;
        end
    end

    assign cmpl_valid_o = cv_q;
    assign cmpl_id_o    = cid_q;
    assign cmpl_resp_o  = cresp_q;
    assign cmpl_user_o  = cuser_q;
    assign cmpl_unexp_o = cunexp_q;
    assign outst_cnt_o  = total_q;

    // Response statistics; unexpected beats still count toward okay/err.
    axi4_sat_counter #(.W(CNT_W)) u_okay_cnt (
        .clk_i  (axi_clk_i),
        .rstn_i (axi_rstn_i),
        .inc_i  (b_fire && !is_err_resp(axi_bresp_i)),
        .cnt_o  (okay_cnt_o)
    );

    axi4_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_i  (axi_clk_i),
        .rstn_i (axi_rstn_i),
        .inc_i  (b_fire && is_err_resp(axi_bresp_i)),
        .cnt_o  (err_cnt_o)
    );

    axi4_sat_counter #(.W(CNT_W)) u_unexp_cnt (
        .clk_i  (axi_clk_i),
        .rstn_i (axi_rstn_i),
        .inc_i  (b_fire && !b_hit),
        .cnt_o  (unexp_cnt_o)
    );

endmodule

// File: tb/tb_axi4_wr_resp_receiver.sv
// Directed bench with a completion scoreboard; statistics use a narrow width
// so saturation is reached within the directed sequence.
module tb_axi4_wr_resp_receiver;
    import axi4_globals_pkg::*;

    localparam int IW = 4;
    localparam int UW = 4;
    localparam int MO = 8;
    localparam int CW = 3;
    localparam int OW = $clog2(MO+1);

    logic          clk, rstn;
    logic          issue_valid, issue_ready;
    logic [IW-1:0] issue_id;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic [UW-1:0] buser;
    logic          bvalid, bready;
    logic          cmpl_valid, cmpl_ready, cmpl_unexp;
    logic [IW-1:0] cmpl_id;
    logic [1:0]    cmpl_resp;
    logic [UW-1:0] cmpl_user;
    logic [OW-1:0] outst;
    logic [CW-1:0] okay_cnt, err_cnt, unexp_cnt;

    axi4_wr_resp_receiver #(.AXI_IW(IW), .AXI_UW(UW), .MAX_OUTST(MO), .CNT_W(CW)) dut (
        .axi_clk_i     (clk),
        .axi_rstn_i    (rstn),
        .issue_valid_i (issue_valid),
        .issue_id_i    (issue_id),
        .issue_ready_o (issue_ready),
        .axi_bid_i     (bid),
        .axi_bresp_i   (bresp),
        .axi_buser_i   (buser),
        .axi_bvalid_i  (bvalid),
        .axi_bready_o  (bready),
        .cmpl_valid_o  (cmpl_valid),
        .cmpl_ready_i  (cmpl_ready),
        .cmpl_id_o     (cmpl_id),
        .cmpl_resp_o   (cmpl_resp),
        .cmpl_user_o   (cmpl_user),
        .cmpl_unexp_o  (cmpl_unexp),
        .outst_cnt_o   (outst),
        .okay_cnt_o    (okay_cnt),
        .err_cnt_o     (err_cnt),
        .unexp_cnt_o   (unexp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int resp;
        int user;
        int unexp;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic int sat(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    // Monitor: a record presented with ready high is consumed at the next edge.
    always @(negedge clk) begin
        if (rstn && cmpl_valid && cmpl_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL cmpl_extra: got id %0d want no record", int'(cmpl_id));
            end else begin
                mon_e = exp_q.pop_front();
                chk("cmpl_id",    int'(cmpl_id),    mon_e.id);
                chk("cmpl_resp",  int'(cmpl_resp),  mon_e.resp);
                chk("cmpl_user",  int'(cmpl_user),  mon_e.user);
                chk("cmpl_unexp", int'(cmpl_unexp), mon_e.unexp);
            end
        end
    end

    // One cycle of stimulus; a B beat is expected to be accepted.
    task automatic cyc(input int iv, input int iid, input int bv, input int b_id,
                       input int resp, input int user, input int unexp);
        issue_valid = (iv != 0);
        issue_id    = IW'(iid);
        bvalid      = (bv != 0);
        bid         = IW'(b_id);
        bresp       = 2'(resp);
        buser       = UW'(user);
        if (bv != 0) exp_q.push_back('{b_id, resp, user, unexp});
        @(posedge clk); #1;
        issue_valid = 1'b0;
        bvalid      = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_outst"},       int'(outst),       0);
        chk({tag, "_issue_ready"}, int'(issue_ready), 1);
        chk({tag, "_bready"},      int'(bready),      1);
        chk({tag, "_cmpl_valid"},  int'(cmpl_valid),  0);
        chk({tag, "_cmpl_id"},     int'(cmpl_id),     0);
        chk({tag, "_cmpl_resp"},   int'(cmpl_resp),   0);
        chk({tag, "_cmpl_user"},   int'(cmpl_user),   0);
        chk({tag, "_cmpl_unexp"},  int'(cmpl_unexp),  0);
        chk({tag, "_okay"},        int'(okay_cnt),    0);
        chk({tag, "_err"},         int'(err_cnt),     0);
        chk({tag, "_unexp"},       int'(unexp_cnt),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rstn = 1'b0; issue_valid = 1'b0; issue_id = '0; bvalid = 1'b0;
        bid = '0; bresp = '0; buser = '0; cmpl_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Issue 3,3,5 then retire 5 and 3 back to back.
        cyc(1, 3, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0);
        chk("outst_3", int'(outst), 3);
        cyc(0, 0, 1, 5, OKAY, 1, 0);
        cyc(0, 0, 1, 3, OKAY, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("outst_1", int'(outst), 1);
        chk("okay_2",  int'(okay_cnt), 2);
        chk("err_0",   int'(err_cnt), 0);
        chk("unexp_0", int'(unexp_cnt), 0);

        // Unexpected DECERR on ID 7.
        cyc(0, 0, 1, 7, DECERR, 10, 1);
        chk("unexp_flag", int'(cmpl_unexp), 1);
        chk("outst_unexp", int'(outst), 1);
        chk("unexp_1", int'(unexp_cnt), 1);
        chk("err_1",   int'(err_cnt), 1);

        // Fill to MAX_OUTST.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 0, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0, 0);
        chk("outst_full", int'(outst), 8);
        chk("issue_ready_full", int'(issue_ready), 0);
        cyc(1, 9, 0, 0, 0, 0, 0);
        chk("outst_ignored", int'(outst), 8);
        // Issue while full plus retirement: issue still ignored.
        cyc(1, 9, 1, 0, EXOKAY, 3, 0);
        chk("outst_full_b", int'(outst), 7);
        chk("issue_ready_back", int'(issue_ready), 1);
        // ID 9 never counted, so its response is unexpected.
        cyc(0, 0, 1, 9, SLVERR, 6, 1);
        chk("outst_id9", int'(outst), 7);
        chk("err_2",   int'(err_cnt), 2);
        chk("unexp_2", int'(unexp_cnt), 2);

        // Same-ID issue and retire nets to zero on ID 2.
        cyc(1, 2, 1, 2, OKAY, 7, 0);
        chk("outst_same", int'(outst), 7);
        cyc(0, 0, 1, 2, OKAY, 8, 0);
        cyc(0, 0, 1, 2, OKAY, 9, 1);
        chk("outst_id2", int'(outst), 6);
        chk("unexp_3", int'(unexp_cnt), 3);
        // Different IDs in the same cycle.
        cyc(1, 4, 1, 1, OKAY, 1, 0);
        chk("outst_diff", int'(outst), 6);
        cyc(0, 0, 1, 4, OKAY, 2, 0);
        cyc(0, 0, 1, 4, EXOKAY, 3, 0);
        chk("outst_4", int'(outst), 4);
        chk("okay_sat9", int'(okay_cnt), sat(9));
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Completion backpressure.
        cmpl_ready = 1'b0;
        cyc(0, 0, 1, 3, SLVERR, 5, 0);
        chk("bp_bready", int'(bready), 0);
        chk("bp_valid",  int'(cmpl_valid), 1);
        bvalid = 1'b1; bid = 4'd5; bresp = OKAY; buser = 4'hC;
        exp_q.push_back('{5, 0, 12, 0});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_id",     int'(cmpl_id), 3);
            chk("hold_resp",   int'(cmpl_resp), 2);
            chk("hold_user",   int'(cmpl_user), 5);
            chk("hold_bready", int'(bready), 0);
        end
        chk("hold_outst", int'(outst), 3);
        cmpl_ready = 1'b1;
        #1;
        chk("release_bready", int'(bready), 1);
        @(posedge clk); #1;
        bvalid = 1'b0;
        chk("release_outst", int'(outst), 2);
        chk("release_id", int'(cmpl_id), 5);
        chk("err_3", int'(err_cnt), 3);
        cyc(1, 10, 0, 0, 0, 0, 0);
        cyc(1, 11, 0, 0, 0, 0, 0);
        chk("outst_re4", int'(outst), 4);
        chk("okay_sat10", int'(okay_cnt), sat(10));

        // Reset mid-traffic with a held completion and 4 outstanding.
        cmpl_ready = 1'b0;
        cyc(1, 12, 1, 6, OKAY, 1, 0);
        chk("pre_rst_outst", int'(outst), 4);
        chk("pre_rst_valid", int'(cmpl_valid), 1);
        exp_q.delete();
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(posedge clk); #1;
        rstn = 1'b1;
        cmpl_ready = 1'b1;
        @(posedge clk); #1;
        // State discarded: ID 6 no longer outstanding.
        cyc(0, 0, 1, 6, OKAY, 0, 1);
        chk("post_rst_unexp", int'(unexp_cnt), 1);
        chk("post_rst_okay",  int'(okay_cnt), 1);
        chk("post_rst_outst", int'(outst), 0);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4_wr_resp_receiver.md
# axi4_wr_resp_receiver

Master-side receiver for the AXI4 write response (B) channel: the counterpart of the slave-side response driver. It records every write ID issued on the AW channel and accepts B beats under `axi_bready_o` flow control. Each B beat is matched against the outstanding IDs and handed to the master sequencer as a completion record. It flags unexpected IDs and error responses and keeps saturating response statistics.

## Interface
Parameters:
- `AXI_IW`, 4, ID width
- `AXI_UW`, 4, BUSER width
- `MAX_OUTST`, 8, maximum outstanding writes, all IDs combined (≥1)
- `CNT_W`, 16, statistics counter width

Ports:
- `axi_clk_i`  in  1  clock; all logic on rising edge
- `axi_rstn_i`  in  1  reset, asynchronous, active-low
- `issue_valid_i`  in  1  AW handshake completed this cycle; push `issue_id_i`
- `issue_id_i`  in  AXI_IW  ID of issued write
- `issue_ready_o`  out  1  outstanding capacity available
- `axi_bid_i`  in  AXI_IW  BID
- `axi_bresp_i`  in  2  BRESP
- `axi_buser_i`  in  AXI_UW  BUSER
- `axi_bvalid_i`  in  1  BVALID
- `axi_bready_o`  out  1  BREADY
- `cmpl_valid_o`  out  1  completion record valid
- `cmpl_ready_i`  in  1  consumer accepts record
- `cmpl_id_o`  out  AXI_IW  completed ID
- `cmpl_resp_o`  out  2  BRESP of completion
- `cmpl_user_o`  out  AXI_UW  BUSER of completion
- `cmpl_unexp_o`  out  1  BID had no outstanding write
- `outst_cnt_o`  out  $clog2(MAX_OUTST+1)  total outstanding writes
- `okay_cnt_o`, `err_cnt_o`, `unexp_cnt_o`  out  CNT_W  saturating statistics

## Operation
- Per-ID outstanding counter array: 2^AXI_IW entries, each $clog2(MAX_OUTST+1) bits. A total counter drives `outst_cnt_o`.
- `issue_ready_o` = (total < MAX_OUTST). An issue counts only when `issue_valid_i && issue_ready_o`. An issue while full is ignored and leaves counters unchanged.
- B handshake = `axi_bvalid_i && axi_bready_o`.
- `axi_bready_o` = !`cmpl_valid_o` || `cmpl_ready_i` (combinational). The block never stalls B except on completion backpressure.
- On a B handshake:
  - If cnt[BID] > 0: decrement cnt[BID] and total; `cmpl_unexp` = 0.
  - Else: counters unchanged; `cmpl_unexp` = 1; `unexp_cnt` +1.
- BRESP OKAY (00) and EXOKAY (01) increment `okay_cnt`. SLVERR (10) and DECERR (11) increment `err_cnt`. These counts apply to unexpected beats too.
- Completion record register: loaded on the B handshake. It holds while `cmpl_valid_o && !cmpl_ready_i`. It clears when accepted with no new handshake.
- Simultaneous issue and B on the same ID: cnt[ID] and total net unchanged. Different IDs: one increments and the other decrements in the same cycle.
- Issue while full and B in the same cycle: the issue is still ignored because `issue_ready_o` is evaluated on pre-edge state.
- All statistics counters saturate at 2^CNT_W−1.

## Timing
- Reset (async assert, sync release by the system):
  - All counters 0.
  - `cmpl_valid_o`=0; `cmpl_id_o`/`cmpl_resp_o`/`cmpl_user_o`/`cmpl_unexp_o`=0.
  - `issue_ready_o`=1; `axi_bready_o`=1.
- Reset mid-operation discards all outstanding state and any pending completion.
- Latency: a B handshake at edge N gives `cmpl_valid_o`=1 after edge N. Counters update at edge N.
- Back-to-back B beats are sustained at one per cycle while `cmpl_ready_i`=1.
- Valid/ready rule: a held completion's fields are stable until accepted.

## Structure
- `axi4_globals_pkg`: `bresp_e` enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the `is_err_resp()` function.
- One sub-module: `axi4_sat_counter` (parameterised width, inc enable). It is instantiated three times for the statistics.

## Test plan
- Issue IDs 3,3,5 → `outst_cnt_o`=3. B with ID 5 then ID 3 (OKAY) → two completions, no unexp, `outst_cnt_o`=1, `okay_cnt_o`=2.
- Issue 8 writes (MAX_OUTST=8) → `issue_ready_o`=0. A 9th `issue_valid_i` is ignored. One B → `issue_ready_o`=1 the next cycle.
- B with ID 7 when none is outstanding, BRESP=DECERR → `cmpl_unexp_o`=1, `unexp_cnt_o`=1, `err_cnt_o`=1, `outst_cnt_o` unchanged.
- Hold `cmpl_ready_i`=0 after one B → `axi_bready_o`=0 and the record is stable. Release → the next B is accepted the following cycle.
- Issue ID 2 and B ID 2 in the same cycle with cnt[2]=1 → cnt[2] stays 1, total unchanged.
- Assert `axi_rstn_i`=0 mid-traffic with 4 outstanding → all outputs return to reset values immediately, without waiting for a clock edge.
